ru_buffer_scheduler: RTL and testbench
======================================

Name: ru_buffer_scheduler

Overview:
- Controller for the recompute-unit (RU) data buffer in the BISR recompute-unit approach.
- CONFIG phase: takes faulty-PE coordinates reported by BIST and assigns each one to a free RU slot. It then drives the per-RU row/col lookup addresses.
- RUN phase: round-robin arbitration between RU write requesters for the buffer's single write port. Produces the registered write strobe, address and data.

Parameters:
- ROWS, 4, systolic array rows.
- COLS, 4, systolic array columns.
- NUM_RU, 4, number of recompute units / fault slots.
- WORD_SIZE, 16, buffer data width.
- ROW_W, $clog2(ROWS), row index width (derived).
- COL_W, $clog2(COLS), column index width (derived).
- CNT_W, $clog2(NUM_RU+1), fault count width (derived).

Ports:
- clk  in  1  system clock; all state on posedge.
- rst  in  1  synchronous, active-high reset.
- cfg_start  in  1  pulse; starts CONFIG, clears slot table (honoured in IDLE only).
- fault_valid  in  1  BIST fault report valid (CONFIG only).
- fault_row  in  ROW_W  faulty PE row.
- fault_col  in  COL_W  faulty PE column.
- cfg_done  in  1  end of fault list; CONFIG->RUN.
- run_stop  in  1  RUN->IDLE.
- wr_req  in  NUM_RU  per-RU write request; held until granted.
- wr_data  in  NUM_RU x WORD_SIZE  per-RU write data (unpacked array).
- wr_gnt  out  NUM_RU  one-hot grant, combinational, same cycle as request.
- ru_active  out  NUM_RU  slot i holds a fault.
- ru_row  out  NUM_RU x ROW_W  row assigned to RU i (buffer read address).
- ru_col  out  NUM_RU x COL_W  column assigned to RU i.
- fault_count  out  CNT_W  number of slots filled.
- overflow  out  1  sticky; a fault was dropped because the table was full.
- busy_cfg  out  1  state==CONFIG.
- busy_run  out  1  state==RUN.
- buf_we  out  1  registered buffer write enable.
- buf_row  out  ROW_W  registered write row.
- buf_col  out  COL_W  registered write column.
- buf_data  out  WORD_SIZE  registered write data.

Behaviour:
- Reset values: all outputs 0, state IDLE, rr pointer 0, slot table cleared. A reset mid-CONFIG or mid-RUN aborts immediately; there is no pending write afterwards.
- FSM:
  - IDLE -(cfg_start)-> CONFIG.
  - CONFIG -(cfg_done)-> RUN.
  - RUN -(run_stop)-> IDLE.
  - cfg_start outside IDLE, cfg_done outside CONFIG and run_stop outside RUN are ignored.
- Entering CONFIG clears ru_active, fault_count and overflow. ru_row/ru_col keep stale values but are qualified by ru_active.
- CONFIG, fault_valid=1:
  - Duplicate (matches any active slot's row/col): ignored.
  - Else if fault_count<NUM_RU: written to slot fault_count. ru_active bit, ru_row/ru_col and count update next cycle.
  - Else: overflow<=1, fault dropped.
- fault_valid and cfg_done in the same cycle: the fault is processed, then the FSM moves to RUN.
- IDLE keeps the table, so a stop/restart of RUN needs no reconfiguration.
- RUN arbitration:
  - Eligible set = wr_req & ru_active. Requests from inactive slots are never granted.
  - Grant goes to the first eligible index starting at rr pointer, searching upward and wrapping at NUM_RU-1 to 0.
  - At most one grant per cycle; wr_gnt is all-zero when nothing is eligible or the state is not RUN.
  - On a grant to i, the pointer becomes (i+1) mod NUM_RU. With no grant the pointer holds.
  - The requester samples wr_gnt on the same edge and drops or advances its request the next cycle.
- Write latency 1:
  - The edge after a grant to i gives buf_we=1, buf_row=ru_row[i], buf_col=ru_col[i], buf_data=wr_data[i].
  - With no grant, buf_we=0 and buf_row/col/data hold their values.
- run_stop in the same cycle as a grant: the grant is honoured (write issued next cycle), then IDLE.
- Back-to-back grants allow one buffer write per cycle; no bubbles.

Test Plan:
- Reset, cfg_start, faults (1,2),(3,0), cfg_done -> fault_count=2, ru_active=0011, ru_row[0]=1/ru_col[0]=2, ru_row[1]=3/ru_col[1]=0, busy_run=1.
- CONFIG with 5 distinct faults, NUM_RU=4 -> fault_count=4, overflow=1, 5th fault absent. Repeated (1,2) -> fault_count unchanged.
- RUN with all 4 active, wr_req=1111 held continuously -> grants 0001,0010,0100,1000,0001. buf_we high every cycle after the first, buf_data tracking the granted wr_data one cycle later.
- 2 active slots, wr_req=1100 -> wr_gnt=0000, buf_we stays 0. Then wr_req=0010 with wr_data[1]=16'hBEEF -> next cycle buf_we=1, buf_row=3, buf_col=0, buf_data=16'hBEEF.
- rst asserted mid-RUN with wr_req=1111 -> next cycle IDLE, all outputs 0, rr pointer 0, ru_active=0000.
- run_stop with a grant the same cycle -> buf_we=1 the next cycle, state IDLE, table retained; a later cfg_start clears it.

Source files
------------

// File: rtl/ru_buffer_scheduler.sv
// Recompute-unit buffer controller: assigns BIST-reported faulty PEs to RU slots,
// then round-robin arbitrates RU writes onto the buffer's single write port.
module ru_buffer_scheduler #(
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int NUM_RU    = 4,
  parameter int WORD_SIZE = 16,
  parameter int ROW_W     = $clog2(ROWS),
  parameter int COL_W     = $clog2(COLS),
  parameter int CNT_W     = $clog2(NUM_RU + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_start,
  input  logic                 fault_valid,
  input  logic [ROW_W-1:0]     fault_row,
  input  logic [COL_W-1:0]     fault_col,
  input  logic                 cfg_done,
  input  logic                 run_stop,
  input  logic [NUM_RU-1:0]    wr_req,
  input  logic [WORD_SIZE-1:0] wr_data [NUM_RU],
  output logic [NUM_RU-1:0]    wr_gnt,
  output logic [NUM_RU-1:0]    ru_active,
  output logic [ROW_W-1:0]     ru_row [NUM_RU],
  output logic [COL_W-1:0]     ru_col [NUM_RU],
  output logic [CNT_W-1:0]     fault_count,
  output logic                 overflow,
  output logic                 busy_cfg,
  output logic                 busy_run,
  output logic                 buf_we,
  output logic [ROW_W-1:0]     buf_row,
  output logic [COL_W-1:0]     buf_col,
  output logic [WORD_SIZE-1:0] buf_data
);

  localparam int PTR_W = (NUM_RU > 1) ? $clog2(NUM_RU) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CONFIG = 2'd1;
  localparam logic [1:0] S_RUN    = 2'd2;

  logic [1:0]           state;
  logic [PTR_W-1:0]     rr_ptr;
  logic [NUM_RU-1:0]    elig;
  logic                 gnt_any;
  logic [PTR_W-1:0]     gnt_idx;
  logic [PTR_W-1:0]     idx_c;
  logic                 dup;
  logic                 vld_p1;
  logic [ROW_W-1:0]     row_p1;
  logic [COL_W-1:0]     col_p1;
  logic [WORD_SIZE-1:0] data_p1;

  assign elig     = wr_req & ru_active;
  assign busy_cfg = (state == S_CONFIG);
  assign busy_run = (state == S_RUN);

  // Search upward from the pointer, wrapping, and take the first eligible slot.
  always_comb begin
    wr_gnt  = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx_c   = '0;
    if (state == S_RUN) begin
      for (int k = 0; k < NUM_RU; k++) begin
        idx_c = PTR_W'((int'(rr_ptr) + k) % NUM_RU);
        if (!gnt_any && elig[idx_c]) begin
          gnt_any        = 1'b1;
          gnt_idx        = idx_c;
          wr_gnt[idx_c]  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    dup = 1'b0;
    for (int i = 0; i < NUM_RU; i++) begin
      if (ru_active[i] && ru_row[i] == fault_row && ru_col[i] == fault_col)
        dup = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      rr_ptr      <= '0;
      ru_active   <= '0;
      fault_count <= '0;
      overflow    <= 1'b0;
      for (int i = 0; i < NUM_RU; i++) begin
        ru_row[i] <= '0;
        ru_col[i] <= '0;
      end
    end else begin
      if (gnt_any)
        rr_ptr <= (gnt_idx == PTR_W'(NUM_RU - 1)) ? '0 : gnt_idx + 1'b1;
      case (state)
        S_IDLE: begin
          if (cfg_start) begin
            state       <= S_CONFIG;
            ru_active   <= '0;
            fault_count <= '0;
            overflow    <= 1'b0;
          end
        end
        S_CONFIG: begin
          if (fault_valid && !dup) begin
            if (fault_count < CNT_W'(NUM_RU)) begin
              for (int i = 0; i < NUM_RU; i++) begin
                if (CNT_W'(i) == fault_count) begin
                  ru_active[i] <= 1'b1;
                  ru_row[i]    <= fault_row;
                  ru_col[i]    <= fault_col;
                end
              end
              fault_count <= fault_count + 1'b1;
            end else begin
              overflow <= 1'b1;
            end
          end
          if (cfg_done)
            state <= S_RUN;
        end
        S_RUN: begin
          if (run_stop)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Stage p1: registered buffer write port, one write per grant
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      row_p1  <= '0;
      col_p1  <= '0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= gnt_any;
      if (gnt_any) begin
        row_p1  <= ru_row[gnt_idx];
        col_p1  <= ru_col[gnt_idx];
        data_p1 <= wr_data[gnt_idx];
      end
    end
  end

  assign buf_we   = vld_p1;
  assign buf_row  = row_p1;
  assign buf_col  = col_p1;
  assign buf_data = data_p1;

endmodule

// File: tb/tb_ru_buffer_scheduler.sv
// Directed bench for ru_buffer_scheduler: expected buffer writes are queued at
// stimulus time and popped by an independent monitor whenever buf_we is seen.
module tb_ru_buffer_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_start, fault_valid, cfg_done, run_stop;
  logic [1:0]  fault_row, fault_col;
  logic [3:0]  wr_req;
  logic [15:0] wr_data [4];
  logic [3:0]  wr_gnt, ru_active;
  logic [1:0]  ru_row [4];
  logic [1:0]  ru_col [4];
  logic [2:0]  fault_count;
  logic        overflow, busy_cfg, busy_run, buf_we;
  logic [1:0]  buf_row, buf_col;
  logic [15:0] buf_data;

  int n_checks = 0;
  int n_pass   = 0;
  logic [19:0] exp_q [$];

  ru_buffer_scheduler dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .fault_valid(fault_valid),
    .fault_row(fault_row), .fault_col(fault_col), .cfg_done(cfg_done),
    .run_stop(run_stop), .wr_req(wr_req), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .ru_active(ru_active), .ru_row(ru_row), .ru_col(ru_col),
    .fault_count(fault_count), .overflow(overflow), .busy_cfg(busy_cfg),
    .busy_run(busy_run), .buf_we(buf_we), .buf_row(buf_row), .buf_col(buf_col),
    .buf_data(buf_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fault(input logic [1:0] r, input logic [1:0] c);
    fault_valid = 1'b1; fault_row = r; fault_col = c;
    step();
    fault_valid = 1'b0;
  endtask

  task automatic expect_wr(input logic [1:0] r, input logic [1:0] c, input logic [15:0] d);
    exp_q.push_back({r, c, d});
  endtask

  always @(negedge clk) begin
    if (buf_we) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_write: got row=%0d col=%0d data=%h expected no write",
                 buf_row, buf_col, buf_data);
      end else begin
        logic [19:0] e;
        e = exp_q.pop_front();
        if ({buf_row, buf_col, buf_data} === e) n_pass++;
        else $display("FAIL buf_write: got row=%0d col=%0d data=%h expected row=%0d col=%0d data=%h",
                      buf_row, buf_col, buf_data, e[19:18], e[17:16], e[15:0]);
      end
    end
  end

  logic [3:0] exp_g [5];
  int         exp_i [5];
  logic [1:0] slot_r [4];
  logic [1:0] slot_c [4];

  initial begin
    rst = 1'b1; cfg_start = 0; fault_valid = 0; cfg_done = 0; run_stop = 0;
    fault_row = 0; fault_col = 0; wr_req = 4'b1111;
    for (int j = 0; j < 4; j++) wr_data[j] = 16'h0;
    step(); step();
    check("rst_count", 32'(fault_count), 0);
    check("rst_active", 32'(ru_active), 0);
    check("rst_busy", 32'({busy_cfg, busy_run, buf_we, overflow}), 0);
    check("rst_gnt", 32'(wr_gnt), 0);
    rst = 1'b0; wr_req = 4'b0;

    // Basic two-fault configuration
    cfg_start = 1'b1; step(); cfg_start = 1'b0;
    check("cfg_busy", 32'(busy_cfg), 1);
    fault(2'd1, 2'd2);
    fault(2'd3, 2'd0);
    cfg_done = 1'b1; step(); cfg_done = 1'b0;
    check("cfg2_count", 32'(fault_count), 2);
    check("cfg2_active", 32'(ru_active), 32'b0011);
    check("cfg2_slot0", 32'({ru_row[0], ru_col[0]}), 32'({2'd1, 2'd2}));
    check("cfg2_slot1", 32'({ru_row[1], ru_col[1]}), 32'({2'd3, 2'd0}));
    check("cfg2_run", 32'(busy_run), 1);

    // Requests only from inactive slots are never granted
    wr_req = 4'b1100; #1;
    check("inactive_gnt", 32'(wr_gnt), 0);
    step();
    check("inactive_we", 32'(buf_we), 0);
    wr_req = 4'b0010; wr_data[1] = 16'hBEEF; #1;
    check("beef_gnt", 32'(wr_gnt), 32'b0010);
    expect_wr(2'd3, 2'd0, 16'hBEEF);
    step(); wr_req = 4'b0;
    check("beef_we", 32'(buf_we), 1);

    // Grant coincident with run_stop: write still issued, table retained
    wr_req = 4'b0001; wr_data[0] = 16'h1234; run_stop = 1'b1; #1;
    check("stop_gnt", 32'(wr_gnt), 32'b0001);
    expect_wr(2'd1, 2'd2, 16'h1234);
    step(); wr_req = 4'b0001; run_stop = 1'b0;
    check("stop_state", 32'({busy_cfg, busy_run}), 0);
    check("stop_we", 32'(buf_we), 1);
    check("stop_table", 32'({ru_active, 1'b0, fault_count}), 32'({4'b0011, 1'b0, 3'd2}));
    check("idle_gnt", 32'(wr_gnt), 0);
    step(); wr_req = 4'b0;
    check("idle_we", 32'(buf_we), 0);

    // Reconfigure: clear, duplicate, overflow, fault with cfg_done same cycle
    cfg_start = 1'b1; step(); cfg_start = 1'b0;
    check("clr_table", 32'({ru_active, overflow, fault_count}), 0);
    wr_req = 4'b1111; #1;
    check("cfg_gnt", 32'(wr_gnt), 0);
    wr_req = 4'b0;
    fault(2'd0, 2'd0);
    fault(2'd0, 2'd1);
    fault(2'd0, 2'd1);
    check("dup_count", 32'(fault_count), 2);
    fault(2'd1, 2'd0);
    fault(2'd1, 2'd1);
    check("full_noovf", 32'({overflow, fault_count}), 32'({1'b0, 3'd4}));
    fault_valid = 1'b1; fault_row = 2'd2; fault_col = 2'd2; cfg_done = 1'b1;
    step(); fault_valid = 1'b0; cfg_done = 1'b0;
    check("ovf_flag", 32'({overflow, fault_count}), 32'({1'b1, 3'd4}));
    check("ovf_active", 32'(ru_active), 32'b1111);
    check("ovf_slot3", 32'({ru_row[3], ru_col[3]}), 32'({2'd1, 2'd1}));
    check("ovf_run", 32'(busy_run), 1);

    // Held 1111 requests; pointer sits at 1 after the earlier grant to slot 0
    slot_r = '{2'd0, 2'd0, 2'd1, 2'd1};
    slot_c = '{2'd0, 2'd1, 2'd0, 2'd1};
    exp_g = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    exp_i = '{1, 2, 3, 0, 1};
    wr_req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      for (int j = 0; j < 4; j++) wr_data[j] = 16'h1000 * 16'(k + 1) + 16'(j);
      #1;
      check($sformatf("rr_gnt%0d", k), 32'(wr_gnt), 32'(exp_g[k]));
      expect_wr(slot_r[exp_i[k]], slot_c[exp_i[k]], 16'h1000 * 16'(k + 1) + 16'(exp_i[k]));
      step();
      if (k > 0) check($sformatf("rr_we%0d", k), 32'(buf_we), 1);
    end

    // Reset mid-RUN with requests pending: no write afterwards, all cleared
    rst = 1'b1; step(); rst = 1'b0; #1;
    check("mid_rst_state", 32'({busy_cfg, busy_run, overflow, fault_count}), 0);
    check("mid_rst_active", 32'(ru_active), 0);
    check("mid_rst_buf", 32'({buf_we, buf_row, buf_col, buf_data}), 0);
    check("mid_rst_slot1", 32'({ru_row[1], ru_col[1]}), 0);
    check("mid_rst_gnt", 32'(wr_gnt), 0);
    wr_req = 4'b0;

    // Pointer back at 0: with slots 0 and 2 requesting, slot 0 wins
    cfg_start = 1'b1; step(); cfg_start = 1'b0;
    fault(2'd2, 2'd3);
    fault(2'd3, 2'd1);
    fault(2'd0, 2'd2);
    fault(2'd3, 2'd3);
    cfg_done = 1'b1; step(); cfg_done = 1'b0;
    wr_req = 4'b0101; wr_data[0] = 16'hCAFE; wr_data[2] = 16'hD00D; #1;
    check("rr0_gnt", 32'(wr_gnt), 32'b0001);
    expect_wr(2'd2, 2'd3, 16'hCAFE);
    step(); wr_req = 4'b0100; #1;
    check("rr0_next_gnt", 32'(wr_gnt), 32'b0100);
    expect_wr(2'd0, 2'd2, 16'hD00D);
    step(); wr_req = 4'b0;
    step(); step();
    check("queue_drained", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
